// File: rtl/vt52_pkg.sv
// Shared definitions for the VT52-style terminal character buffer:
// command opcodes, blank fill code and the write engine state encoding.
package vt52_pkg;

  localparam logic [2:0] OP_WRITE      = 3'd0;
  localparam logic [2:0] OP_CLR_SCREEN = 3'd1;
  localparam logic [2:0] OP_CLR_EOL    = 3'd2;
  localparam logic [2:0] OP_CLR_EOS    = 3'd3;
  localparam logic [2:0] OP_SCROLL_UP  = 3'd4;
  localparam logic [2:0] OP_SCROLL_DN  = 3'd5;

  localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_COPY_RD = 3'd2,
    ST_COPY_WR = 3'd3,
    ST_DONE    = 3'd4
  } engine_state_t;

endpackage

// File: rtl/char_buffer_engine.sv
// Write-port sequencer for the shared character buffer. Turns one terminal
// command at a time into single-cell accesses on buffer port A. Scrolls copy
// cells physically because the display scans row*COLS+col with no base offset.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_FILL    | one write per cycle at dst (blank fill or the WRITE char)
// ST_COPY_RD | read issued at src, no write
// ST_COPY_WR | write read data to dst, then step both pointers
// ST_DONE    | no-access command (reserved op or bad coordinate) completes
module char_buffer_engine
  import vt52_pkg::*;
#(
  parameter int         ROWS       = 24,
  parameter int         COLS       = 80,
  parameter int         ROW_BITS   = 5,
  parameter int         COL_BITS   = 7,
  parameter int         ADDR_BITS  = 11,
  parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [7:0]           cmd_char,
  input  logic [COL_BITS-1:0]  cmd_x,
  input  logic [ROW_BITS-1:0]  cmd_y,
  output logic                 done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  localparam logic [ADDR_BITS-1:0] COLS_A      = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] COLS_M1_A   = ADDR_BITS'(COLS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_A      = ADDR_BITS'(ROWS * COLS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ROW_A  = ADDR_BITS'((ROWS - 1) * COLS);
  localparam logic [ADDR_BITS-1:0] UP_CPY_END  = ADDR_BITS'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_BITS-1:0] DN_SRC_INIT = ADDR_BITS'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_BITS-1:0] ONE_A       = ADDR_BITS'(1);
  localparam logic [COL_BITS-1:0]  COLS_X      = COL_BITS'(COLS);
  localparam logic [ROW_BITS-1:0]  ROWS_Y      = ROW_BITS'(ROWS);

  engine_state_t        state;
  logic [ADDR_BITS-1:0] dst;
  logic [ADDR_BITS-1:0] src;
  logic [ADDR_BITS-1:0] end_addr;
  logic [7:0]           fill_data;
  logic                 scroll_dn;

  logic [ADDR_BITS-1:0] row_base;
  logic [ADDR_BITS-1:0] cell_addr;
  logic [ADDR_BITS-1:0] eol_end;
  logic                 coord_oob;

  // Cell addresses for the incoming command's coordinates
  always_comb begin
    row_base  = ADDR_BITS'(cmd_y) * COLS_A;
    cell_addr = row_base + ADDR_BITS'(cmd_x);
    eol_end   = row_base + COLS_M1_A;
    coord_oob = (cmd_x >= COLS_X) || (cmd_y >= ROWS_Y);
  end

  // Command sequencer: accept, fill, copy and completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dst       <= '0;
      src       <= '0;
      end_addr  <= '0;
      fill_data <= '0;
      scroll_dn <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            fill_data <= BLANK_CHAR;
            scroll_dn <= 1'b0;
            case (cmd_op)
              OP_WRITE: begin
                if (coord_oob) begin
                  state <= ST_DONE;
                end else begin
                  state     <= ST_FILL;
                  dst       <= cell_addr;
                  end_addr  <= cell_addr;
                  fill_data <= cmd_char;
                end
              end
              OP_CLR_SCREEN: begin
                state    <= ST_FILL;
                dst      <= '0;
                end_addr <= LAST_A;
              end
              OP_CLR_EOL: begin
                if (coord_oob) begin
                  state <= ST_DONE;
                end else begin
                  state    <= ST_FILL;
                  dst      <= cell_addr;
                  end_addr <= eol_end;
                end
              end
              OP_CLR_EOS: begin
                if (coord_oob) begin
                  state <= ST_DONE;
                end else begin
                  state    <= ST_FILL;
                  dst      <= cell_addr;
                  end_addr <= LAST_A;
                end
              end
              OP_SCROLL_UP: begin
                state    <= ST_COPY_RD;
                dst      <= '0;
                src      <= COLS_A;
                end_addr <= UP_CPY_END;
              end
              OP_SCROLL_DN: begin
                state     <= ST_COPY_RD;
                dst       <= LAST_A;
                src       <= DN_SRC_INIT;
                end_addr  <= COLS_A;
                scroll_dn <= 1'b1;
              end
              default: state <= ST_DONE;
            endcase
          end
        end
        ST_FILL: begin
          if (dst == end_addr) begin
            state <= ST_IDLE;
          end else begin
            dst <= dst + ONE_A;
          end
        end
        ST_COPY_RD: begin
          state <= ST_COPY_WR;
        end
        ST_COPY_WR: begin
          if (dst == end_addr) begin
            // Copy finished; blank the row that was vacated
            state <= ST_FILL;
            if (scroll_dn) begin
              dst      <= '0;
              end_addr <= COLS_M1_A;
            end else begin
              dst      <= LAST_ROW_A;
              end_addr <= LAST_A;
            end
          end else begin
            state <= ST_COPY_RD;
            if (scroll_dn) begin
              dst <= dst - ONE_A;
              src <= src - ONE_A;
            end else begin
              dst <= dst + ONE_A;
              src <= src + ONE_A;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Port-A drive decoded from registered state; read data only feeds wdata
  always_comb begin
    cmd_ready = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = dst;
        mem_wdata = fill_data;
        done      = (dst == end_addr);
      end
      ST_COPY_RD: begin
        mem_addr = src;
      end
      ST_COPY_WR: begin
        mem_we    = 1'b1;
        mem_addr  = dst;
        mem_wdata = mem_rdata;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_char_buffer_engine.sv
// Scoreboard bench for char_buffer_engine: a reference model of the screen
// predicts every port-A write; a negedge monitor checks them in order.
module tb_char_buffer_engine;
  import vt52_pkg::*;

  localparam int ROWS  = 24;
  localparam int COLS  = 80;
  localparam int CELLS = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_char = '0;
  logic [6:0]  cmd_x = '0;
  logic [4:0]  cmd_y = '0;
  logic        done;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        preload = 1'b0;

  always #5 clk = ~clk;

  char_buffer_engine dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_char  (cmd_char),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Buffer RAM with one-cycle synchronous read, plus a one-shot pattern load
  logic [7:0] ram [0:CELLS-1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < CELLS; i++) ram[i] <= i[7:0];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic       nowrite;
    int         addr;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [0:CELLS-1];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic void push_w(input int a, input logic [7:0] d);
    model[a] = d;
    exp_q.push_back('{1'b0, a, d, 1'b0});
  endfunction

  // Screen-level model: apply the command to the model image, queue the
  // writes it implies in order, and return cycles from accept to done.
  function automatic int build(input int op, input int ch, input int x, input int y);
    int  lat = 0;
    int  idx;
    bit  oob = (x >= COLS) || (y >= ROWS);
    bit  nw  = 1'b0;
    case (op)
      0: if (oob) nw = 1'b1; else begin push_w(y * COLS + x, ch[7:0]); lat = 1; end
      1: for (int a = 0; a < CELLS; a++) begin push_w(a, 8'h20); lat++; end
      2: if (oob) nw = 1'b1;
         else for (int a = y * COLS + x; a < y * COLS + COLS; a++) begin push_w(a, 8'h20); lat++; end
      3: if (oob) nw = 1'b1;
         else for (int a = y * COLS + x; a < CELLS; a++) begin push_w(a, 8'h20); lat++; end
      4: begin
        for (int d = 0; d < CELLS - COLS; d++) begin push_w(d, model[d + COLS]); lat += 2; end
        for (int a = CELLS - COLS; a < CELLS; a++) begin push_w(a, 8'h20); lat++; end
      end
      5: begin
        for (int d = CELLS - 1; d >= COLS; d--) begin push_w(d, model[d - COLS]); lat += 2; end
        for (int a = 0; a < COLS; a++) begin push_w(a, 8'h20); lat++; end
      end
      default: nw = 1'b1;
    endcase
    if (nw) begin
      exp_q.push_back('{1'b1, 0, 8'h00, 1'b1});
      lat = 1;
    end else begin
      idx = exp_q.size() - 1;
      exp_q[idx].last = 1'b1;
    end
    return lat;
  endfunction

  // Monitor: every write or done pulse must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (mem_we === 1'b1 || done === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_access: got we=%0b addr=%0d data=%h done=%0b, expected no access",
                 mem_we, mem_addr, mem_wdata, done);
      end else begin
        e = exp_q.pop_front();
        if (e.nowrite) begin
          if (mem_we !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL nowrite_done: got we=%0b done=%0b, expected we=0 done=1", mem_we, done);
          end
        end else if (mem_we !== 1'b1 || mem_addr !== e.addr[10:0] ||
                     mem_wdata !== e.data || done !== e.last) begin
          fails++;
          $display("FAIL write_seq: got we=%0b addr=%0d data=%h done=%0b, expected addr=%0d data=%h done=%0b",
                   mem_we, mem_addr, mem_wdata, done, e.addr, e.data, e.last);
        end
      end
    end
  end

  task automatic load_pattern();
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    for (int i = 0; i < CELLS; i++) model[i] = i[7:0];
  endtask

  task automatic check_image(input string name);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) if (ram[i] !== model[i]) bad++;
    chk(name, bad, 0);
  endtask

  // Issue one command from idle, keep junk on cmd_* while busy, then check
  // latency, ready recovery, queue drain and the full buffer image.
  task automatic run_cmd(input string name, input int op, input int ch, input int x, input int y);
    int lat;
    int n = 0;
    lat = build(op, ch, x, y);
    chk({name, "_ready_before"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op[2:0];
    cmd_char  = ch[7:0];
    cmd_x     = x[6:0];
    cmd_y     = y[4:0];
    @(posedge clk); #1;
    cmd_op   = 3'($urandom);
    cmd_char = 8'($urandom);
    cmd_x    = 7'($urandom);
    cmd_y    = 5'($urandom);
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 8000);
    cmd_valid = 1'b0;
    if (done !== 1'b1) $display("FAIL %s_timeout: no done after %0d cycles, expected %0d", name, n, lat);
    chk({name, "_latency"}, n, lat);
    @(posedge clk); #1;
    chk({name, "_ready_after"}, int'(cmd_ready), 1);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
    check_image({name, "_image"});
  endtask

  initial begin
    int op;
    int scrolls = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_we", int'(mem_we), 0);
    chk("reset_addr", int'(mem_addr), 0);
    chk("reset_wdata", int'(mem_wdata), 0);

    load_pattern();
    run_cmd("write_corner", 0, 8'h41, 79, 23);
    run_cmd("clr_eol", 2, 0, 10, 2);

    load_pattern();
    run_cmd("scroll_up", 4, 0, 0, 0);
    load_pattern();
    run_cmd("scroll_down", 5, 0, 0, 0);

    run_cmd("write_x80", 0, 8'h55, 80, 0);
    run_cmd("op6", 6, 0, 0, 0);
    run_cmd("op7", 7, 0, 3, 3);
    run_cmd("eos_y24", 3, 0, 0, 24);
    run_cmd("eol_last_col", 2, 0, 79, 0);

    // Reset during CLR_SCREEN: writes to 0..98 land, the rest is abandoned
    load_pattern();
    for (int a = 0; a < 99; a++) push_w(a, 8'h20);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR_SCREEN;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (98) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_we", int'(mem_we), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check_image("abort_image");

    for (int k = 0; k < 25; k++) begin
      op = $urandom_range(0, 7);
      if (op == 4 || op == 5) begin
        if (scrolls >= 2) op = 2;
        else scrolls++;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_cmd("random", op, $urandom_range(0, 255), $urandom_range(0, 85), $urandom_range(0, 26));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
